// File: rtl/alu_rs_pkg.sv
// Shared constants and encodings for the ALU reservation station slice.
package alu_rs_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 5;
  localparam int UNIT_W = 2;

  // A producer tag of zero marks an operand whose value is already present.
  localparam logic [TAG_W-1:0] TAG_READY = '0;

  // Execution-unit selector carried by every issued instruction.
  typedef enum logic [UNIT_W-1:0] {
    UNIT_NONE = 2'd0,
    UNIT_ALU  = 2'd1,
    UNIT_LSU  = 2'd2,
    UNIT_BRU  = 2'd3
  } unitSel_e;

endpackage

// File: rtl/alu_rs_age_matrix.sv
// Age matrix for the reservation station: r_older[i][j] means entry i was
// written before entry j. Produces a one-hot grant for the oldest ready entry.
module rs_age_matrix #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] i_alloc,
  input  logic [DEPTH-1:0] i_free,
  input  logic             i_clear,
  input  logic [DEPTH-1:0] i_ready,
  output logic [DEPTH-1:0] o_grant
);

  logic [DEPTH-1:0] r_older [DEPTH];
  logic [DEPTH-1:0] w_blocked;

  // A new entry is younger than everything else; a freed or reallocated entry forgets its history.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_older[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (i_alloc[j] && (i != j)) begin
            r_older[i][j] <= 1'b1;
          end else if (i_alloc[i] || i_free[i] || i_free[j]) begin
            r_older[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // A ready entry wins unless some other ready entry is older than it.
  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (i_ready[j] && r_older[j][i]) begin
          w_blocked[i] = 1'b1;
        end
      end
    end
    o_grant = i_ready & ~w_blocked;
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: captures toggle-encoded issues for this unit, wakes
// operands from the CDB and dispatches the oldest ready entry over valid/ready.
module alu_rs #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = alu_rs_pkg::DATA_W,
  parameter int TAG_W   = alu_rs_pkg::TAG_W,
  parameter int OP_W    = alu_rs_pkg::OP_W,
  parameter int UNIT_W  = alu_rs_pkg::UNIT_W,
  parameter int UNIT_ID = int'(alu_rs_pkg::UNIT_ALU)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_ce,
  input  logic [UNIT_W-1:0]      in_unit,
  input  logic [OP_W-1:0]        in_op,
  input  logic [DATA_W-1:0]      in_val1,
  input  logic [DATA_W-1:0]      in_val2,
  input  logic [TAG_W-1:0]       in_tag1,
  input  logic [TAG_W-1:0]       in_tag2,
  input  logic [TAG_W-1:0]       in_target,
  input  logic [DATA_W-1:0]      in_pc_addr,
  input  logic [DATA_W-1:0]      in_offset,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [DATA_W-1:0]      cdb_val,
  input  logic                   flush,
  output logic                   alu_valid,
  input  logic                   alu_ready,
  output logic [OP_W-1:0]        alu_op,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [TAG_W-1:0]       alu_target,
  output logic [DATA_W-1:0]      alu_pc_addr,
  output logic [DATA_W-1:0]      alu_offset,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  import alu_rs_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entry storage
  logic [DEPTH-1:0]  r_valid;
  logic [OP_W-1:0]   r_op     [DEPTH];
  logic [DATA_W-1:0] r_val1   [DEPTH];
  logic [DATA_W-1:0] r_val2   [DEPTH];
  logic [TAG_W-1:0]  r_tag1   [DEPTH];
  logic [TAG_W-1:0]  r_tag2   [DEPTH];
  logic [TAG_W-1:0]  r_target [DEPTH];
  logic [DATA_W-1:0] r_pc     [DEPTH];
  logic [DATA_W-1:0] r_offset [DEPTH];

  // Issue tracking and status
  logic r_lastCe;
  logic r_overflow;

  // Dispatch output register
  logic              r_aluValid;
  logic [OP_W-1:0]   r_aluOp;
  logic [DATA_W-1:0] r_aluA;
  logic [DATA_W-1:0] r_aluB;
  logic [TAG_W-1:0]  r_aluTarget;
  logic [DATA_W-1:0] r_aluPc;
  logic [DATA_W-1:0] r_aluOffset;

  // Combinational helpers
  logic              w_new;
  logic              w_forUs;
  logic              w_full;
  logic              w_accept;
  logic              w_bypass1;
  logic              w_bypass2;
  logic              w_found;
  logic [DEPTH-1:0]  w_allocSel;
  logic [DEPTH-1:0]  w_alloc;
  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_grant;
  logic [DEPTH-1:0]  w_free;
  logic              w_anyReady;
  logic              w_canDispatch;
  logic [CNT_W-1:0]  w_count;
  logic [OP_W-1:0]   w_selOp;
  logic [DATA_W-1:0] w_selA;
  logic [DATA_W-1:0] w_selB;
  logic [TAG_W-1:0]  w_selTarget;
  logic [DATA_W-1:0] w_selPc;
  logic [DATA_W-1:0] w_selOffset;

  assign w_new         = (in_ce != r_lastCe);
  assign w_forUs       = (in_unit == UNIT_W'(UNIT_ID));
  assign w_full        = &r_valid;
  assign w_accept      = w_new && w_forUs && !w_full && !flush;
  assign w_bypass1     = cdb_valid && (in_tag1 != TAG_READY) && (in_tag1 == cdb_tag);
  assign w_bypass2     = cdb_valid && (in_tag2 != TAG_READY) && (in_tag2 == cdb_tag);
  assign w_alloc       = w_accept ? w_allocSel : '0;
  assign w_canDispatch = !r_aluValid || alu_ready;
  assign w_anyReady    = |w_grant;
  assign w_free        = (w_canDispatch && !flush) ? w_grant : '0;

  // Pick the lowest-index free slot for the next accepted instruction.
  always_comb begin
    w_allocSel = '0;
    w_found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_valid[i] && !w_found) begin
        w_allocSel[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  // Readiness looks only at registered tags, so a wakeup takes effect one cycle later.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_valid[i] && (r_tag1[i] == TAG_READY) && (r_tag2[i] == TAG_READY);
    end
  end

  // Population count of occupied entries.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CNT_W'(r_valid[i]);
    end
  end

  // One-hot mux of the granted entry's payload.
  always_comb begin
    w_selOp     = '0;
    w_selA      = '0;
    w_selB      = '0;
    w_selTarget = '0;
    w_selPc     = '0;
    w_selOffset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        w_selOp     = w_selOp | r_op[i];
        w_selA      = w_selA | r_val1[i];
        w_selB      = w_selB | r_val2[i];
        w_selTarget = w_selTarget | r_target[i];
        w_selPc     = w_selPc | r_pc[i];
        w_selOffset = w_selOffset | r_offset[i];
      end
    end
  end

  rs_age_matrix #(
    .DEPTH (DEPTH)
  ) u_ageMatrix (
    .clk     (clk),
    .rst     (rst),
    .i_alloc (w_alloc),
    .i_free  (w_free),
    .i_clear (flush),
    .i_ready (w_ready),
    .o_grant (w_grant)
  );

  // Remember the last issue-strobe level so every level change counts as one issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastCe <= 1'b0;
    end else begin
      r_lastCe <= in_ce;
    end
  end

  // Entry occupancy: dispatch frees, accept allocates, flush empties everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= (r_valid & ~w_free) | w_alloc;
    end
  end

  // Entry payload: write on allocate (with CDB bypass), otherwise snoop the CDB for wakeups.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc[i]) begin
        r_op[i]     <= in_op;
        r_target[i] <= in_target;
        r_pc[i]     <= in_pc_addr;
        r_offset[i] <= in_offset;
        r_tag1[i]   <= w_bypass1 ? TAG_READY : in_tag1;
        r_val1[i]   <= w_bypass1 ? cdb_val : in_val1;
        r_tag2[i]   <= w_bypass2 ? TAG_READY : in_tag2;
        r_val2[i]   <= w_bypass2 ? cdb_val : in_val2;
      end else if (r_valid[i]) begin
        if (cdb_valid && (r_tag1[i] != TAG_READY) && (r_tag1[i] == cdb_tag)) begin
          r_tag1[i] <= TAG_READY;
          r_val1[i] <= cdb_val;
        end
        if (cdb_valid && (r_tag2[i] != TAG_READY) && (r_tag2[i] == cdb_tag)) begin
          r_tag2[i] <= TAG_READY;
          r_val2[i] <= cdb_val;
        end
      end
    end
  end

  // Sticky flag for an issue that arrived while every slot was occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_new && w_forUs && w_full && !flush) begin
      r_overflow <= 1'b1;
    end
  end

  // Dispatch register: load the oldest ready entry whenever the slot is empty or being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluValid  <= 1'b0;
      r_aluOp     <= '0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluTarget <= '0;
      r_aluPc     <= '0;
      r_aluOffset <= '0;
    end else if (flush) begin
      r_aluValid <= 1'b0;
    end else if (w_canDispatch) begin
      r_aluValid <= w_anyReady;
      if (w_anyReady) begin
        r_aluOp     <= w_selOp;
        r_aluA      <= w_selA;
        r_aluB      <= w_selB;
        r_aluTarget <= w_selTarget;
        r_aluPc     <= w_selPc;
        r_aluOffset <= w_selOffset;
      end
    end
  end

  assign alu_valid   = r_aluValid;
  assign alu_op      = r_aluOp;
  assign alu_a       = r_aluA;
  assign alu_b       = r_aluB;
  assign alu_target  = r_aluTarget;
  assign alu_pc_addr = r_aluPc;
  assign alu_offset  = r_aluOffset;
  assign full        = w_full;
  assign count       = w_count;
  assign overflow    = r_overflow;

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the ALU execution unit. Sits directly downstream of the ID/EX pipeline register.
- Captures each issued instruction whose unit field selects the ALU, holds it until both operands are ready, and dispatches the oldest ready entry to the ALU through a valid/ready handshake.
- Operand readiness is resolved by snooping the common data bus (CDB).

Parameters:
DEPTH, 4, number of station entries (power of two, 2..8)
DATA_W, 32, operand/result width
TAG_W, 4, ROB tag width; tag value 0 means "operand ready"
OP_W, 5, ALU opcode width
UNIT_W, 2, execution-unit selector width
UNIT_ID, 1, in_unit value that selects this station

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_ce  in  1  issue strobe, toggle-encoded: every change of level is one new instruction
in_unit  in  UNIT_W  target execution unit of the issued instruction
in_op  in  OP_W  ALU opcode
in_val1/in_val2  in  DATA_W  operand values, meaningful when the matching tag is 0
in_tag1/in_tag2  in  TAG_W  producer tags, 0 = ready
in_target  in  TAG_W  destination ROB tag
in_pc_addr  in  DATA_W  instruction PC
in_offset  in  DATA_W  immediate/offset
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_val  in  DATA_W  broadcast value
flush  in  1  discard all contents (mispredict)
alu_valid  out  1  dispatch valid
alu_ready  in  1  ALU accepts this cycle
alu_op/alu_a/alu_b/alu_target/alu_pc_addr/alu_offset  out  as inputs  dispatched instruction
full  out  1  all DEPTH entries occupied (combinational from valid bits)
count  out  $clog2(DEPTH)+1  occupied entries
overflow  out  1  sticky: a toggle for UNIT_ID arrived while full

Behaviour:
- Reset: all entry valid bits = 0, age matrix = 0, last_ce = 0, alu_valid = 0, all alu_* data outputs = 0, full = 0, count = 0, overflow = 0. in_ce must be held at 0 while rst is high.
- Toggle detect: new = (in_ce != last_ce). last_ce <= in_ce every non-reset cycle, whatever the unit, full or flush state.
- Accept: new && in_unit == UNIT_ID && !full && !flush.
  - Write to the lowest-index free entry; that entry becomes youngest in the age matrix.
  - Same-cycle bypass: if cdb_valid && cdb_tag == in_tagN && in_tagN != 0, store tag 0 and value cdb_val.
- Drop on full: new && in_unit == UNIT_ID && full -> instruction discarded, overflow <= 1 (cleared only by rst). Upstream must stall on full.
- Wakeup: each cycle, every valid entry with tagN == cdb_tag (cdb_valid, tagN != 0) stores valN <= cdb_val and tagN <= 0.
- Ready: entry valid && tag1 == 0 && tag2 == 0, evaluated from registered state only. An entry woken at edge N becomes selectable in cycle N+1.
- Select/dispatch: when !alu_valid || alu_ready, load the oldest ready entry into the alu_* output registers, alu_valid <= 1, and clear that entry's valid bit on the same edge.
  - With no ready entry: alu_valid <= 0.
  - Outputs hold stable while alu_valid && !alu_ready.
- Latency: instruction with ready operands toggled in during cycle N is written at edge N and appears as alu_valid after edge N+1 (minimum 2 cycles from toggle).
- A slot freed at an edge is allocatable in the next cycle. Accept and dispatch in the same cycle are allowed whenever !full.
- Operand mapping: alu_a = val1, alu_b = val2. op/target/pc_addr/offset pass through unchanged.
- Flush (highest priority after rst): at the next edge all entries invalid, age matrix cleared, alu_valid <= 0. Any in-flight toggle that cycle is discarded. overflow is unaffected.
- count and full reflect entry valid bits only; the output register is not counted.

Decomposition:
- Shared constants go in common_def.h: DATA_W, TAG_W, OP_W, UNIT_W, unit encodings (UNIT_ALU etc.), TAG_READY = 0.
- One sub-module, rs_age_matrix (DEPTH×DEPTH older-than bits). Inputs: alloc one-hot, free one-hot, clear, ready vector. Output: one-hot oldest-ready grant.

Test Plan:
- Reset, toggle in_ce 0->1 with unit=1, op=3, tag1=tag2=0, val1=5, val2=7, alu_ready=1 -> alu_valid after 2 edges with alu_a=5, alu_b=7; count returns to 0.
- Issue with tag1=3, then cdb_valid tag=3 val=0x10 two cycles later -> dispatch occurs exactly one cycle after the CDB edge, with alu_a=0x10.
- Issue with tag2=4 while cdb_tag=4 val=9 in the same cycle -> entry is ready immediately, alu_b=9, same latency as the first scenario.
- alu_ready=0, four toggles fill the station -> full=1, count=4. A fifth toggle for unit 1 -> overflow=1 and count stays 4. A fifth toggle for unit 2 -> ignored, overflow unchanged.
- Three ready entries A,B,C issued in order, alu_ready held 0 then released -> dispatch order A,B,C. alu outputs stay stable during the stall.
- Two entries waiting plus alu_valid=1, assert flush for 1 cycle -> next cycle alu_valid=0, count=0. A following toggle is accepted normally.
